// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the radix-2 FFT datapath
package fft_pkg;

  localparam int TW_W      = 16;
  localparam int TW_FRAC   = 13;
  localparam int TW_ADDR_W = 5;
  localparam int N_POINTS  = 64;

  // Added before the >>> so the product rounds half up
  localparam int RND_CONST = 1 << (TW_FRAC - 1);

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } cplx_tw_t;

endpackage

// File: rtl/fft_butterfly_if.sv
// rtl/fft_butterfly_if.sv - operand/result stream bundle of the butterfly
interface fft_butterfly_if
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = DATA_W + 2
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_W-1:0]    a_re;
  logic signed [DATA_W-1:0]    a_im;
  logic signed [DATA_W-1:0]    b_re;
  logic signed [DATA_W-1:0]    b_im;
  logic        [TW_ADDR_W-1:0] tw_idx;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_W-1:0]     x_re;
  logic signed [OUT_W-1:0]     x_im;
  logic signed [OUT_W-1:0]     y_re;
  logic signed [OUT_W-1:0]     y_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, tw_idx, out_ready,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, tw_idx, out_ready,
    output in_ready, out_valid, x_re, x_im, y_re, y_im
  );

endinterface

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - registered complex product b*W with rounded combinational t
module fft_cmul
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  cplx_tw_t                 w,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] a_re_q,
  output logic signed [DATA_W-1:0] a_im_q,
  output logic signed [OUT_W-1:0]  t_re,
  output logic signed [OUT_W-1:0]  t_im
);

  localparam int PW = DATA_W + TW_W;

  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   s_re, s_im;

  assign p_rr_d = PW'(b_re) * PW'(w.re);
  assign p_ii_d = PW'(b_im) * PW'(w.im);
  assign p_ri_d = PW'(b_re) * PW'(w.im);
  assign p_ir_d = PW'(b_im) * PW'(w.re);

  // Products stand in for the sampled twiddle: holding them holds W across a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      a_re_q    <= '0;
      a_im_q    <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        p_rr   <= p_rr_d;
        p_ii   <= p_ii_d;
        p_ri   <= p_ri_d;
        p_ir   <= p_ir_d;
        a_re_q <= a_re;
        a_im_q <= a_im;
      end
    end
  end

  assign s_re = (PW+1)'(p_rr) - (PW+1)'(p_ii) + (PW+1)'(RND_CONST);
  assign s_im = (PW+1)'(p_ri) + (PW+1)'(p_ir) + (PW+1)'(RND_CONST);
  assign t_re = OUT_W'(s_re >>> TW_FRAC);
  assign t_im = OUT_W'(s_im >>> TW_FRAC);

endmodule

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - pipelined radix-2 DIT butterfly; FFT_BFLY_SCALE_EN halves x/y
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = DATA_W + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fft_butterfly_if.slave              bus,
  output logic        [TW_ADDR_W-1:0] tw_addr,
  input  logic signed [TW_W-1:0]      tw_re,
  input  logic signed [TW_W-1:0]      tw_im
);

  logic                     en;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] a1_re, a1_im, b1_re, b1_im;
  logic                     c_valid;
  logic signed [DATA_W-1:0] c_a_re, c_a_im;
  logic signed [OUT_W-1:0]  t_re, t_im;
  logic signed [OUT_W:0]    sx_re, sx_im, sy_re, sy_im;
  cplx_tw_t                 w;

  // The whole pipeline freezes only when the output register is blocked
  assign en          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a1_re    <= '0;
      a1_im    <= '0;
      b1_re    <= '0;
      b1_im    <= '0;
      tw_addr  <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a1_re   <= bus.a_re;
        a1_im   <= bus.a_im;
        b1_re   <= bus.b_re;
        b1_im   <= bus.b_im;
        tw_addr <= bus.tw_idx;
      end
    end
  end

  assign w = '{re: tw_re, im: tw_im};

  fft_cmul #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_cmul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (s1_valid),
    .a_re     (a1_re),
    .a_im     (a1_im),
    .b_re     (b1_re),
    .b_im     (b1_im),
    .w        (w),
    .out_valid(c_valid),
    .a_re_q   (c_a_re),
    .a_im_q   (c_a_im),
    .t_re     (t_re),
    .t_im     (t_im)
  );

  // One spare bit so the optional +1 before halving cannot wrap
  assign sx_re = (OUT_W+1)'(c_a_re) + (OUT_W+1)'(t_re);
  assign sx_im = (OUT_W+1)'(c_a_im) + (OUT_W+1)'(t_im);
  assign sy_re = (OUT_W+1)'(c_a_re) - (OUT_W+1)'(t_re);
  assign sy_im = (OUT_W+1)'(c_a_im) - (OUT_W+1)'(t_im);

  function automatic logic signed [OUT_W-1:0] out_fmt(input logic signed [OUT_W:0] v);
`ifdef FFT_BFLY_SCALE_EN
    return OUT_W'((v + (OUT_W+1)'(1)) >>> 1);
`else
    return OUT_W'(v);
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.x_re      <= '0;
      bus.x_im      <= '0;
      bus.y_re      <= '0;
      bus.y_im      <= '0;
    end else if (en) begin
      bus.out_valid <= c_valid;
      if (c_valid) begin
        bus.x_re <= out_fmt(sx_re);
        bus.x_im <= out_fmt(sx_im);
        bus.y_re <= out_fmt(sy_re);
        bus.y_im <= out_fmt(sy_im);
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// tb/tb_fft_butterfly.sv - vector table plus scoreboarded random streams for fft_butterfly
module tb_fft_butterfly;
  import fft_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [TW_ADDR_W-1:0] tw_addr;
  logic signed [15:0]   tw_re, tw_im;
  logic signed [15:0]   rom_re [32];
  logic signed [15:0]   rom_im [32];

  fft_butterfly_if #(.DATA_W(16), .OUT_W(18)) bus ();

  fft_butterfly #(.DATA_W(16), .OUT_W(18)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .tw_addr(tw_addr),
    .tw_re  (tw_re),
    .tw_im  (tw_im)
  );

  always #5 clk = ~clk;

  assign tw_re = rom_re[tw_addr];
  assign tw_im = rom_im[tw_addr];

  typedef struct { int xr; int xi; int yr; int yi; } exp_t;
  typedef struct { int ar; int ai; int br; int bi; int idx; int xr; int xi; int yr; int yi; } vec_t;

  int   checks = 0;
  int   passed = 0;
  int   out_cnt = 0;
  bit   sb_on = 0;
  bit   acc = 0;
  exp_t q[$];
  vec_t vt[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int scale(input int v);
`ifdef FFT_BFLY_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi, input int idx);
    longint wr = longint'(rom_re[idx]);
    longint wi = longint'(rom_im[idx]);
    longint tr = (br * wr - bi * wi + 4096) >>> 13;
    longint ti = (br * wi + bi * wr + 4096) >>> 13;
    exp_t e;
    e.xr = scale(ar + int'(tr));
    e.xi = scale(ai + int'(ti));
    e.yr = scale(ar - int'(tr));
    e.yi = scale(ai - int'(ti));
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string nm);
    chk({nm, "_x_re"}, int'(bus.x_re), e.xr);
    chk({nm, "_x_im"}, int'(bus.x_im), e.xi);
    chk({nm, "_y_re"}, int'(bus.y_re), e.yr);
    chk({nm, "_y_im"}, int'(bus.y_im), e.yi);
  endtask

  task automatic monitor();
    exp_t e;
    acc = rst_n && bus.in_valid && bus.in_ready;
    if (rst_n && sb_on) begin
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (q.size() == 0) chk("extra_out", 1, 0);
        else begin
          e = q.pop_front();
          cmp(e, "stream");
        end
      end else if (bus.out_valid && q.size() > 0) begin
        cmp(q[0], "stall_hold");
      end
      if (acc) q.push_back(model(int'(bus.a_re), int'(bus.a_im), int'(bus.b_re),
                                 int'(bus.b_im), int'(bus.tw_idx)));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat();
    bus.a_re   = 16'($urandom);
    bus.a_im   = 16'($urandom);
    bus.b_re   = 16'($urandom);
    bus.b_im   = 16'($urandom);
    bus.tw_idx = 5'($urandom);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((q.size() > 0 || bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_left_in_queue"}, q.size(), 0);
  endtask

  initial begin
    int lat;
    int sent;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0; bus.tw_idx = '0;
    for (int i = 0; i < 32; i++) begin
      rom_re[i] = 16'(int'($urandom_range(16384)) - 8192);
      rom_im[i] = 16'(int'($urandom_range(16384)) - 8192);
    end
    rom_re[0] = 16'h2000;  rom_im[0] = 16'h0000;
    rom_re[1] = 16'h1000;  rom_im[1] = 16'h0000;
    rom_re[16] = 16'h1680; rom_im[16] = 16'hE19E;

`ifdef FFT_BFLY_SCALE_EN
    vt[0] = '{100, 0, 200, 0, 0, 150, 0, -50, 0};
    vt[1] = '{0, 0, 8192, 0, 16, 2880, -3889, -2880, 3889};
    vt[2] = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
    vt[3] = '{0, 0, -1, 0, 1, 0, 0, 0, 0};
`else
    vt[0] = '{100, 0, 200, 0, 0, 300, 0, -100, 0};
    vt[1] = '{0, 0, 8192, 0, 16, 5760, -7778, -5760, 7778};
    vt[2] = '{0, 0, 1, 0, 1, 1, 0, -1, 0};
    vt[3] = '{0, 0, -1, 0, 1, 0, 0, 0, 0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_x_re", int'(bus.x_re), 0);
    chk("rst_y_im", int'(bus.y_im), 0);
    chk("rst_tw_addr", int'(tw_addr), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 4; i++) begin
      bus.a_re = 16'(vt[i].ar); bus.a_im = 16'(vt[i].ai);
      bus.b_re = 16'(vt[i].br); bus.b_im = 16'(vt[i].bi);
      bus.tw_idx = 5'(vt[i].idx);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_x_re", i), int'(bus.x_re), vt[i].xr);
      chk($sformatf("vec%0d_x_im", i), int'(bus.x_im), vt[i].xi);
      chk($sformatf("vec%0d_y_re", i), int'(bus.y_re), vt[i].yr);
      chk($sformatf("vec%0d_y_im", i), int'(bus.y_im), vt[i].yi);
      tick();
      chk($sformatf("vec%0d_valid_clear", i), int'(bus.out_valid), 0);
    end

    // 64 back-to-back beats: outputs must also appear on 64 consecutive cycles
    sb_on = 1'b1;
    out_cnt = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      new_beat();
      tick();
    end
    chk("thru_out_after_64", out_cnt, 61);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("thru_out_total", out_cnt, 64);
    drain("thru");

    // Four beats against a blocked output for five cycles
    out_cnt = 0;
    sent = 0;
    new_beat();
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = (sent < 4);
      bus.out_ready = (i >= 8);
      if (i >= 3 && i <= 7) chk("stall_in_ready", int'(bus.in_ready), 0);
      tick();
      if (acc) begin
        sent++;
        new_beat();
      end
    end
    drain("bp");
    chk("bp_sent", sent, 4);
    chk("bp_out_count", out_cnt, 4);

    // Random valid/ready; an unaccepted beat is held unchanged
    new_beat();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(99) < 70);
      bus.out_ready = ($urandom_range(99) < 60);
      tick();
      if (acc || !bus.in_valid) new_beat();
    end
    drain("rand");

    // Reset in the middle of a full stream
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      new_beat();
      tick();
    end
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.out_valid), 0);
    chk("async_rst_x_re", int'(bus.x_re), 0);
    q.delete();
    bus.in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_beat", int'(bus.out_valid), 0);
    end
    out_cnt = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_beat();
      tick();
    end
    drain("post_rst");
    chk("post_rst_count", out_cnt, 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
